mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares the single-ported byte-addressed `MEM` data port (`mem_fn`/`addr`/`write_data`/`read_data`) between an instruction-fetch requester and a load/store requester. Each cycle it grants at most one request, registers the winning command, drives the memory from that register in the following cycle, and returns a registered response with alignment checking. It sits between the pipeline's IF/MEM stages and the memory model, so the CPU runs against a single-port memory.

## Interface
- `STARVE_MAX`, default 4: consecutive contested cycles won by data before fetch is forced to win once (1..15).
- `RESET_ADDR`, default 32'h0: value of `m_addr` held after reset.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `i_req`  in  1  fetch request; held until granted.
- `i_addr`  in  32  fetch byte address.
- `i_flush`  in  1  discard any in-flight fetch response (branch redirect).
- `i_gnt`  out  1  combinational; fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch response valid (1-cycle pulse).
- `i_rdata`  out  32  fetched instruction word.
- `i_err`  out  1  fetch address misaligned; qualified by `i_rvalid`.
- `d_req`  in  1  load/store request; held until granted.
- `d_fn`  in  3  `MEM_*` code from `define.vh`.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  combinational; data request accepted this cycle.
- `d_rvalid`  out  1  data response/completion pulse (loads and stores).
- `d_rdata`  out  32  load data, already extended by memory.
- `d_err`  out  1  data misaligned; qualified by `d_rvalid`.
- `m_fn`  out  3  to `MEM.mem_fn`.
- `m_addr`  out  32  to `MEM.addr`.
- `m_wdata`  out  32  to `MEM.write_data`.
- `m_rdata`  in  32  from `MEM.read_data` (combinational in memory).

## Operation
- Arbitration (combinational, in accept cycle): only one requesting -> it wins. Both requesting -> data wins unless `starve_cnt == STARVE_MAX`, then fetch wins.
- `starve_cnt`: increments on each contested cycle won by data; cleared when fetch is granted or when `i_req` is low; saturates at STARVE_MAX.
- On grant edge, command register loads {owner, fn, addr, wdata, err}. Fetch loads fn=`MEM_LW`.
- Misalignment: fetch `addr[1:0]!=0`; `MEM_LW`/`MEM_SW` with `addr[1:0]!=0`; `MEM_LH`/`MEM_LHU`/`MEM_SH` with `addr[0]!=0`. Erroneous commands are issued to memory as `MEM_LW` at `addr & ~3` (no write occurs); response carries err=1 and rdata=0.
- Idle (no command registered): `m_fn=MEM_LW`, `m_addr` holds last value, `m_wdata=0`; no store ever issued while idle.
- Flush: `i_flush` high in a cycle kills the fetch command currently in the command register (its `i_rvalid` never asserts). A fetch granted in the same cycle as `i_flush` is not killed.
- Data commands are never killed.

## Timing
- Cycle N: request granted (`*_gnt`=1). Edge N/N+1: command registered. Cycle N+1: memory driven; store commits at edge N+1/N+2. Edge N+1/N+2: `m_rdata` captured. Cycle N+2: `*_rvalid`=1 with `*_rdata`, `*_err`.
- Latency grant-to-response: 2 cycles. Throughput: one grant per cycle, back-to-back allowed for either requester.
- Reset values: `i_gnt`,`d_gnt`=0 while reset high; `i_rvalid`,`d_rvalid`,`i_err`,`d_err`=0; `i_rdata`,`d_rdata`=0; `m_fn=MEM_LW`, `m_addr=RESET_ADDR`, `m_wdata=0`; `starve_cnt`=0; command register empty.
- Reset asserted mid-operation: in-flight command and pending response dropped; no store issued after reset asserts.
- Requester must hold request fields stable while `req`=1 and `gnt`=0.

## Test plan
- Fetch only: `i_req`, `i_addr=0x10`, memory word 0x00A00513 -> `i_gnt` cycle 0, `i_rvalid` cycle 2 with `i_rdata=0x00A00513`, `i_err=0`.
- Store then load: `d_fn=MEM_SW`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`, then `MEM_LBU` at 0x101 -> second `d_rdata=0x000000BE`; both `d_rvalid` pulses 1 cycle apart.
- Contention with STARVE_MAX=4: both requesting continuously -> data granted 4 cycles, fetch granted cycle 5, data again cycle 6.
- Misaligned `MEM_SW` at 0x102 -> `d_err=1`, `d_rdata=0`, memory at 0x100..0x103 unchanged.
- Flush: fetch granted cycle 0, `i_flush` cycle 1 -> no `i_rvalid` cycle 2; fetch granted in cycle 1 still responds cycle 3.
- Reset asserted during cycle N+1 of a store -> all outputs at reset values, target bytes unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported byte-addressed memory between instruction fetch and load/store.
// One grant per cycle; the winner is registered, drives memory next cycle, and responds the cycle after.
module mem_port_arbiter #(
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [2:0]  d_fn,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [2:0]  m_fn,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  // Memory function codes, matching the MEM model's encoding.
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd3;
  localparam logic [2:0] MEM_LHU = 3'd4;
  localparam logic [2:0] MEM_SB  = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Handshake: a requester holds req and its fields stable until it sees gnt=1
  // in the same cycle; the response follows exactly two cycles after the grant.

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_owner_q, cmd_owner_d;   // 1 = data, 0 = fetch
  logic [2:0]  cmd_fn_q, cmd_fn_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        cmd_err_q, cmd_err_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic fetch_win;
  logic d_misaligned;
  logic [31:0] rsp_data;

  always_comb begin
    d_misaligned = 1'b0;
    case (d_fn)
      MEM_LW, MEM_SW:          d_misaligned = (d_addr[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: d_misaligned = d_addr[0];
      MEM_LB, MEM_LBU, MEM_SB: d_misaligned = 1'b0;
      default:                 d_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    fetch_win = i_req && (!d_req || (starve_cnt_q == STARVE_LIM));
    i_gnt     = !reset && fetch_win;
    d_gnt     = !reset && d_req && !fetch_win;

    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Erroneous commands become a harmless aligned word read so no write can occur.
  always_comb begin
    cmd_valid_d = i_gnt || d_gnt;
    cmd_owner_d = d_gnt;
    cmd_fn_d    = MEM_LW;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = 32'h0;
    cmd_err_d   = 1'b0;
    if (i_gnt) begin
      cmd_err_d  = (i_addr[1:0] != 2'b00);
      cmd_addr_d = cmd_err_d ? {i_addr[31:2], 2'b00} : i_addr;
    end else if (d_gnt) begin
      cmd_err_d   = d_misaligned;
      cmd_fn_d    = d_misaligned ? MEM_LW : d_fn;
      cmd_addr_d  = d_misaligned ? {d_addr[31:2], 2'b00} : d_addr;
      cmd_wdata_d = d_misaligned ? 32'h0 : d_wdata;
    end
  end

  always_comb begin
    rsp_data   = cmd_err_q ? 32'h0 : m_rdata;
    i_rvalid_d = cmd_valid_q && !cmd_owner_q && !i_flush;
    d_rvalid_d = cmd_valid_q && cmd_owner_q;
    i_rdata_d  = i_rvalid_d ? rsp_data : i_rdata_q;
    i_err_d    = i_rvalid_d ? cmd_err_q : i_err_q;
    d_rdata_d  = d_rvalid_d ? rsp_data : d_rdata_q;
    d_err_d    = d_rvalid_d ? cmd_err_q : d_err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      cmd_valid_q  <= 1'b0;
      cmd_owner_q  <= 1'b0;
      cmd_fn_q     <= MEM_LW;
      cmd_addr_q   <= RESET_ADDR;
      cmd_wdata_q  <= 32'h0;
      cmd_err_q    <= 1'b0;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= 32'h0;
      i_err_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'h0;
      d_err_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_owner_q  <= cmd_owner_d;
      cmd_fn_q     <= cmd_fn_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_err_q    <= cmd_err_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      i_err_q      <= i_err_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  // Idle memory cycles are word reads at the last address, never stores.
  always_comb begin
    m_fn    = cmd_valid_q ? cmd_fn_q : MEM_LW;
    m_addr  = cmd_addr_q;
    m_wdata = cmd_valid_q ? cmd_wdata_q : 32'h0;
  end

  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign i_err    = i_err_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;

endmodule
